// File: rtl/rgb_pingpong_seq.sv
// Ping-pong pixel buffer with an R/G/B colour-phase sequencer.
// Fills two DEPTH-pixel banks in turn and drains each full bank one byte per cycle.
//
// Ports:
//   Clock, Reset          rising-edge clock, async active-high reset
//   PixelIn/PixelValid    24-bit {R,G,B} pixel in, qualified by PixelValid
//   PixelReady            write bank is not full
//   OutEnable             downstream accepting bytes; low stalls the sequencer
//   Buf0Out*/Buf1Out*     current pixel of each bank, held between loads
//   SelR/G/B0, SelR/G/B1  one-hot colour strobes per bank
//   LineDone              one-cycle pulse after a bank is fully drained
module rgb_pingpong_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [23:0] PixelIn,
    input  logic        PixelValid,
    output logic        PixelReady,
    input  logic        OutEnable,
    output logic [7:0]  Buf0OutR,
    output logic [7:0]  Buf0OutG,
    output logic [7:0]  Buf0OutB,
    output logic [7:0]  Buf1OutR,
    output logic [7:0]  Buf1OutG,
    output logic [7:0]  Buf1OutB,
    output logic        SelR0,
    output logic        SelG0,
    output logic        SelB0,
    output logic        SelR1,
    output logic        SelG1,
    output logic        SelB1,
    output logic        LineDone
);

    typedef enum logic [1:0] {
        IDLE,
        PH_R,
        PH_G,
        PH_B
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Pixel storage; contents are deliberately left unreset.
    logic [23:0] mem_q [2][DEPTH];

    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]    full_q, full_d;

    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    state_t        state_q, state_d;

    logic [23:0]   buf0_q, buf0_d;
    logic [23:0]   buf1_q, buf1_d;
    logic          line_done_q, line_done_d;

    logic          wr_fire;
    logic          wr_last;
    logic          rd_last;
    logic          load;
    logic          clr_full;
    logic [AW-1:0] load_addr;
    logic [23:0]   load_pix;

    assign PixelReady = !full_q[wr_bank_q];
    assign wr_fire    = PixelValid && PixelReady;
    assign wr_last    = (wr_addr_q == LAST);
    assign rd_last    = (rd_addr_q == LAST);
    assign load_pix   = mem_q[rd_bank_q][load_addr];

    always_ff @(posedge Clock) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr_q] <= PixelIn;
        end
    end

    // Write side
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_addr_d = '0;
                wr_bank_d = !wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // Read sequencer
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        load        = 1'b0;
        load_addr   = rd_addr_q;
        clr_full    = 1'b0;
        line_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = PH_R;
                    load    = 1'b1;
                end
            end
            PH_R: begin
                if (OutEnable) begin
                    state_d = PH_G;
                end
            end
            PH_G: begin
                if (OutEnable) begin
                    state_d = PH_B;
                end
            end
            PH_B: begin
                if (OutEnable) begin
                    if (rd_last) begin
                        clr_full    = 1'b1;
                        rd_addr_d   = '0;
                        rd_bank_d   = !rd_bank_q;
                        line_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        load_addr = rd_addr_q + 1'b1;
                        load      = 1'b1;
                        state_d   = PH_R;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Set and clear always target different banks, so both may apply.
    always_comb begin
        full_d = full_q;
        if (wr_fire && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (load) begin
            if (rd_bank_q) begin
                buf1_d = load_pix;
            end else begin
                buf0_d = load_pix;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            state_q     <= IDLE;
            buf0_q      <= '0;
            buf1_q      <= '0;
            line_done_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            state_q     <= state_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            line_done_q <= line_done_d;
        end
    end

    // Strobes gate on OutEnable so a stalled phase emits nothing.
    assign SelR0 = (state_q == PH_R) && !rd_bank_q && OutEnable;
    assign SelG0 = (state_q == PH_G) && !rd_bank_q && OutEnable;
    assign SelB0 = (state_q == PH_B) && !rd_bank_q && OutEnable;
    assign SelR1 = (state_q == PH_R) &&  rd_bank_q && OutEnable;
    assign SelG1 = (state_q == PH_G) &&  rd_bank_q && OutEnable;
    assign SelB1 = (state_q == PH_B) &&  rd_bank_q && OutEnable;

    assign Buf0OutR = buf0_q[23:16];
    assign Buf0OutG = buf0_q[15:8];
    assign Buf0OutB = buf0_q[7:0];
    assign Buf1OutR = buf1_q[23:16];
    assign Buf1OutG = buf1_q[15:8];
    assign Buf1OutB = buf1_q[7:0];
    assign LineDone = line_done_q;

endmodule

// File: tb/tb_rgb_pingpong_seq.sv
// Testbench for rgb_pingpong_seq.
// Scoreboard of expected colour bytes, filled on accepted writes, drained on strobes.
module tb_rgb_pingpong_seq;

    localparam int DEPTH = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [23:0] PixelIn;
    logic        PixelValid;
    logic        PixelReady;
    logic        OutEnable;
    logic [7:0]  Buf0OutR, Buf0OutG, Buf0OutB;
    logic [7:0]  Buf1OutR, Buf1OutG, Buf1OutB;
    logic        SelR0, SelG0, SelB0;
    logic        SelR1, SelG1, SelB1;
    logic        LineDone;

    rgb_pingpong_seq #(.DEPTH(DEPTH), .AW(3)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PixelIn    (PixelIn),
        .PixelValid (PixelValid),
        .PixelReady (PixelReady),
        .OutEnable  (OutEnable),
        .Buf0OutR   (Buf0OutR),
        .Buf0OutG   (Buf0OutG),
        .Buf0OutB   (Buf0OutB),
        .Buf1OutR   (Buf1OutR),
        .Buf1OutG   (Buf1OutG),
        .Buf1OutB   (Buf1OutB),
        .SelR0      (SelR0),
        .SelG0      (SelG0),
        .SelB0      (SelB0),
        .SelR1      (SelR1),
        .SelG1      (SelG1),
        .SelB1      (SelB1),
        .LineDone   (LineDone)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       bank;
        logic [1:0] col;
        logic [7:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          line_cnt = 0;
    int          ld_count = 0;
    logic        ld_prev = 1'b0;
    logic        last_bank = 1'b0;
    logic        wrap_pend = 1'b0;
    logic [5:0]  sel;
    logic [23:0] buf0, buf1;

    assign sel  = {SelB1, SelG1, SelR1, SelB0, SelG0, SelR0};
    assign buf0 = {Buf0OutR, Buf0OutG, Buf0OutB};
    assign buf1 = {Buf1OutR, Buf1OutG, Buf1OutB};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Called once per falling edge.
    task automatic mon_step();
        exp_t       e;
        logic       b;
        logic [1:0] c;
        logic [7:0] v;
        if (Reset) begin
            sb_q.delete();
            wr_cnt    = 0;
            line_cnt  = 0;
            ld_prev   = 1'b0;
            wrap_pend = 1'b0;
            return;
        end
        if (sel != 6'd0) begin
            chk("onehot", $countones(sel), 1);
            b = |sel[5:3];
            if (sel[0] | sel[3])      c = 2'd0;
            else if (sel[1] | sel[4]) c = 2'd1;
            else                      c = 2'd2;
            case ({b, c})
                3'b000:  v = Buf0OutR;
                3'b001:  v = Buf0OutG;
                3'b010:  v = Buf0OutB;
                3'b100:  v = Buf1OutR;
                3'b101:  v = Buf1OutG;
                default: v = Buf1OutB;
            endcase
            if (line_cnt == 0 && wrap_pend) begin
                chk("wrap_r0", sel, 6'b000001);
                wrap_pend = 1'b0;
            end
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("strobe", {b, c}, {e.bank, e.col});
                chk("byte", v, e.val);
                last_bank = e.bank;
            end
            line_cnt++;
        end
        if (LineDone) begin
            chk("ld_pulse", ld_prev, 0);
            chk("line_len", line_cnt, 3 * DEPTH);
            line_cnt  = 0;
            ld_count++;
            wrap_pend = last_bank;
        end
        ld_prev = LineDone;
        if (PixelValid && PixelReady) begin
            b = ((wr_cnt / DEPTH) % 2) != 0;
            sb_q.push_back('{b, 2'd0, PixelIn[23:16]});
            sb_q.push_back('{b, 2'd1, PixelIn[15:8]});
            sb_q.push_back('{b, 2'd2, PixelIn[7:0]});
            wr_cnt++;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send(input logic [23:0] px, output bit stalled);
        int n;
        stalled    = 0;
        PixelIn    = px;
        PixelValid = 1'b1;
        n = 0;
        forever begin
            @(negedge Clock);
            if (PixelReady) break;
            stalled = 1;
            n++;
            if (n > 200) begin
                chk("ready_timeout", PixelReady, 1);
                break;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (sb_q.size() == 0) break;
        end
        repeat (3) @(negedge Clock);
        chk("drain", sb_q.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_sel(input int idx, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            if (sel[idx]) begin
                hit = 1;
                break;
            end
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        bit          st;
        bit          saw_bp;
        int          ld_base;
        logic [23:0] px;

        Reset      = 1'b1;
        PixelIn    = '0;
        PixelValid = 1'b0;
        OutEnable  = 1'b0;
        fork
            forever begin
                @(negedge Clock);
                mon_step();
            end
        join_none

        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        chk("rst_sel", sel, 0);
        chk("rst_buf0", buf0, 0);
        chk("rst_buf1", buf1, 0);
        chk("rst_ld", LineDone, 0);
        chk("rst_ready", PixelReady, 1);

        // Bank 0 fill and drain, with fill-to-SelR latency
        @(posedge Clock);
        #1 OutEnable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            px = 24'h112233 + 24'(i) * 24'h333333;
            send(px, st);
        end
        PixelValid = 1'b0;
        @(negedge Clock);
        chk("lat_idle", SelR0, 0);
        @(negedge Clock);
        chk("lat_selr0", SelR0, 1);
        chk("buf0_first", buf0, 24'h112233);
        wait_drain(200);
        chk("lines_b0", ld_count, 1);

        // Continuous stream of three banks with backpressure
        ld_base = ld_count;
        saw_bp  = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            px = 24'hA01020 + 24'(i) * 24'h010305;
            send(px, st);
            if (st) saw_bp = 1;
            if (i == 2 * DEPTH) begin
                chk("resume_after_ld", ld_count > ld_base, 1);
            end
        end
        PixelValid = 1'b0;
        chk("bp_seen", saw_bp, 1);
        wait_drain(600);
        chk("lines_pp", ld_count - ld_base, 3);

        // Stall in PH_G
        for (int i = 0; i < DEPTH; i++) begin
            px = 24'h5A6B7C + 24'(i) * 24'h101010;
            send(px, st);
        end
        PixelValid = 1'b0;
        wait_sel(0, "stall_find_r0");
        @(posedge Clock);
        #1 OutEnable = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            chk("stall_sel", sel, 0);
            chk("stall_buf0", buf0, 24'h5A6B7C);
        end
        @(posedge Clock);
        #1 OutEnable = 1'b1;
        @(negedge Clock);
        chk("stall_resume_g0", SelG0, 1);
        wait_drain(300);

        // Async reset in PH_B of a bank 1 line
        for (int i = 0; i < DEPTH; i++) begin
            px = 24'hE0C0A0 - 24'(i) * 24'h020202;
            send(px, st);
        end
        PixelValid = 1'b0;
        wait_sel(5, "find_b1");
        #2 Reset = 1'b1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_buf0", buf0, 0);
        chk("arst_buf1", buf1, 0);
        chk("arst_ld", LineDone, 0);
        chk("arst_ready", PixelReady, 1);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            px = 24'h0F1E2D + 24'(i) * 24'h111111;
            send(px, st);
        end
        PixelValid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("post_rst_r0", SelR0, 1);
        chk("post_rst_buf0", buf0, 24'h0F1E2D);
        wait_drain(200);
        chk("post_rst_buf1", buf1, 0);
        chk("lines_total", ld_count, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
